microsequencer: RTL

MICROSEQUENCER -- requirements
Module: microsequencer

---
 rtl/ctrl_seq_pkg.sv | 21 ++
 rtl/mfc_wait_timer.sv | 37 +++
 rtl/microsequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared definitions for the control-store microsequencer.
//   ns_sel_e           - next-state select encodings of the microinstruction ns_sel field
//   RESET_STATE        - control state entered on reset
//   DEFAULT_TRAP_STATE - default unimplemented/undefined trap state number
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    NsEncode = 3'd0,
    NsInc    = 3'd1,
    NsJump   = 3'd2,
    NsCjmp   = 3'd3,
    NsWait   = 3'd4,
    NsCall   = 3'd5,
    NsRet    = 3'd6,
    NsNcjmp  = 3'd7
  } ns_sel_e;

  localparam int unsigned RESET_STATE        = 0;
  localparam int unsigned DEFAULT_TRAP_STATE = 1;

endpackage

// File: rtl/mfc_wait_timer.sv
// mfc_wait_timer: counts consecutive cycles spent holding in a WAIT microinstruction
// and flags when the memory-function-complete wait has run out.
//   clk      in  rising-edge clock
//   reset    in  asynchronous active-high reset
//   hold_req in  WAIT selected with mfc low this cycle
//   expire   out hold_req while the count has already reached MFC_TIMEOUT
module mfc_wait_timer #(
  parameter int unsigned MFC_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic hold_req,
  output logic expire
);

  localparam int unsigned CNT_W = (MFC_TIMEOUT > 0) ? $clog2(MFC_TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    expire     = hold_req && (wait_cnt_q == CNT_W'(MFC_TIMEOUT));
    wait_cnt_d = '0;
    // Count only while actually holding; the expiring cycle leaves WAIT, so it clears.
    if (hold_req && !expire) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// microsequencer: control-state register and next-state selection for a microcoded
// controller. The registered state addresses the microstore; the fields of the
// addressed microinstruction (ns_sel, ns_addr) pick the following state.
//   clk         in  rising-edge clock
//   reset       in  asynchronous active-high reset
//   ns_sel      in  next-state select (ctrl_seq_pkg::ns_sel_e)
//   ns_addr     in  target state field
//   enc_state   in  next state from the IR encoder
//   cond        in  condition-tester result
//   mfc         in  memory function complete (level)
//   state       out current control state
//   waiting     out WAIT is holding this cycle
//   illegal     out sticky: dispatch to the trap state
//   timeout_err out sticky: mfc wait timed out
// Build option: define SEQ_CALL_RET_EN to enable the single-entry CALL/RET return
// register; otherwise CALL and RET trap as illegal.
module microsequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned STATE_W     = 7,
  parameter int unsigned MFC_TIMEOUT = 15,
  parameter int unsigned TRAP_STATE  = DEFAULT_TRAP_STATE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         ns_sel,
  input  logic [STATE_W-1:0] ns_addr,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               cond,
  input  logic               mfc,
  output logic [STATE_W-1:0] state,
  output logic               waiting,
  output logic               illegal,
  output logic               timeout_err
);

  localparam logic [STATE_W-1:0] TrapVal  = STATE_W'(TRAP_STATE);
  localparam logic [STATE_W-1:0] ResetVal = STATE_W'(RESET_STATE);

  logic [STATE_W-1:0] state_q, state_d, state_inc;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               hold_req, expire;

  assign state_inc = state_q + STATE_W'(1);  // wraps modulo 2^STATE_W
  assign hold_req  = (ns_sel == NsWait) && !mfc;

  mfc_wait_timer #(
    .MFC_TIMEOUT(MFC_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .hold_req(hold_req),
    .expire  (expire)
  );

`ifdef SEQ_CALL_RET_EN
  logic [STATE_W-1:0] ret_q, ret_d;
`endif

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
`ifdef SEQ_CALL_RET_EN
    ret_d     = ret_q;
`endif
    unique case (ns_sel_e'(ns_sel))
      NsEncode: begin
        state_d = enc_state;
        if (enc_state == TrapVal) illegal_d = 1'b1;
      end
      NsInc:    state_d = state_inc;
      NsJump:   state_d = ns_addr;
      NsCjmp:   state_d = cond ? ns_addr : state_inc;
      NsNcjmp:  state_d = cond ? state_inc : ns_addr;
      NsWait: begin
        // mfc wins over an expiring count: a completion on the last cycle is not an error.
        if (mfc) begin
          state_d = state_inc;
        end else if (expire) begin
          state_d   = TrapVal;
          timeout_d = 1'b1;
        end
      end
`ifdef SEQ_CALL_RET_EN
      NsCall: begin
        ret_d   = state_inc;
        state_d = ns_addr;
      end
      NsRet:    state_d = ret_q;
`else
      NsCall, NsRet: begin
        state_d   = TrapVal;
        illegal_d = 1'b1;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ResetVal;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef SEQ_CALL_RET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_q <= '0;
    end else begin
      ret_q <= ret_d;
    end
  end
`endif

  assign state       = state_q;
  assign waiting     = hold_req && !reset;
  assign illegal     = illegal_q;
  assign timeout_err = timeout_q;

endmodule
